// File: rtl/seg_mux_display.sv
// Multiplexed N-digit seven-segment driver: double-buffered nibble value,
// dead-time blanked digit scan, BCD/hex decode, leading-zero suppression.
module seg_mux_display #(
    parameter int DIGITS         = 4,
    parameter int CLK_DIV        = 1000,
    parameter int DEAD_CYCLES    = 2,
    parameter bit HEX_MODE       = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit DIG_ACTIVE_LOW = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  lz_blank,
    output logic [6:0]            seg,
    output logic                  seg_dp,
    output logic [DIGITS-1:0]     dig,
    output logic                  frame_tick
);

    localparam int CNT_MAX = (CLK_DIV > DEAD_CYCLES) ? CLK_DIV : DEAD_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic {BLANK = 1'b0, SHOW = 1'b1} state_t;

    state_t               state_reg, state_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic [IDX_W-1:0]     idx_reg, idx_next;
    logic                 tick_next;

    logic [4*DIGITS-1:0]  pending_reg, active_reg, active_next;
    logic [DIGITS-1:0]    pending_dp_reg, active_dp_reg, active_dp_next;
    logic                 pending_valid_reg;

    logic [3:0]           nibble [DIGITS];
    logic [DIGITS-1:0]    upper_zero;
    logic                 zero_run;
    logic [3:0]           cur_nibble;
    logic                 digit_blank;
    logic [6:0]           seg_on;
    logic                 dp_on;
    logic [DIGITS-1:0]    dig_on;

    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'h0:    decode = 7'b0111111;
            4'h1:    decode = 7'b0000110;
            4'h2:    decode = 7'b1011011;
            4'h3:    decode = 7'b1001111;
            4'h4:    decode = 7'b1100110;
            4'h5:    decode = 7'b1101101;
            4'h6:    decode = 7'b1111101;
            4'h7:    decode = 7'b0000111;
            4'h8:    decode = 7'b1111111;
            4'h9:    decode = 7'b1101111;
            4'hA:    decode = HEX_MODE ? 7'b1110111 : 7'b0000000;
            4'hB:    decode = HEX_MODE ? 7'b1111100 : 7'b0000000;
            4'hC:    decode = HEX_MODE ? 7'b0111001 : 7'b0000000;
            4'hD:    decode = HEX_MODE ? 7'b1011110 : 7'b0000000;
            4'hE:    decode = HEX_MODE ? 7'b1111001 : 7'b0000000;
            default: decode = HEX_MODE ? 7'b1110001 : 7'b0000000;
        endcase
    endfunction

    // The frame_tick cycle is the buffer boundary; a load landing on it bypasses pending.
    always_comb begin
        active_next    = active_reg;
        active_dp_next = active_dp_reg;
        if (frame_tick) begin
            if (load) begin
                active_next    = value;
                active_dp_next = dp;
            end else if (pending_valid_reg) begin
                active_next    = pending_reg;
                active_dp_next = pending_dp_reg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_reg       <= '0;
            pending_dp_reg    <= '0;
            pending_valid_reg <= 1'b0;
            active_reg        <= '0;
            active_dp_reg     <= '0;
        end else begin
            active_reg    <= active_next;
            active_dp_reg <= active_dp_next;
            if (frame_tick) begin
                pending_valid_reg <= 1'b0;
            end else if (load) begin
                pending_reg       <= value;
                pending_dp_reg    <= dp;
                pending_valid_reg <= 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nibble
            assign nibble[gi] = active_next[4*gi +: 4];
        end
    endgenerate

    // upper_zero[i]: nibble i and every more significant nibble are zero.
    always_comb begin
        zero_run   = 1'b1;
        upper_zero = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run      = zero_run && (nibble[i] == 4'd0);
            upper_zero[i] = zero_run;
        end
    end

    assign cur_nibble  = nibble[idx_next];
    assign digit_blank = lz_blank && (idx_next != '0) && upper_zero[idx_next];
    assign seg_on      = digit_blank ? 7'd0 : decode(cur_nibble);
    assign dp_on       = active_dp_next[idx_next];
    assign dig_on      = DIGITS'(1) << idx_next;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        tick_next  = 1'b0;
        if (!enable) begin
            state_next = BLANK;
            cnt_next   = '0;
            idx_next   = '0;
        end else begin
            case (state_reg)
                BLANK: begin
                    if (cnt_reg == CNT_W'(DEAD_CYCLES - 1)) begin
                        state_next = SHOW;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                default: begin
                    if (cnt_reg == CNT_W'(CLK_DIV - 1)) begin
                        state_next = BLANK;
                        cnt_next   = '0;
                        if (idx_reg == IDX_W'(DIGITS - 1)) begin
                            idx_next  = '0;
                            tick_next = 1'b1;
                        end else begin
                            idx_next = idx_reg + 1'b1;
                        end
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            endcase
        end
    end

    // Pin registers are loaded from the next state so dig and seg switch together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= BLANK;
            cnt_reg    <= '0;
            idx_reg    <= '0;
            frame_tick <= 1'b0;
            seg        <= {7{SEG_ACTIVE_LOW}};
            seg_dp     <= SEG_ACTIVE_LOW;
            dig        <= {DIGITS{DIG_ACTIVE_LOW}};
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            idx_reg    <= idx_next;
            frame_tick <= tick_next;
            if (state_next == SHOW) begin
                seg    <= seg_on ^ {7{SEG_ACTIVE_LOW}};
                seg_dp <= dp_on ^ SEG_ACTIVE_LOW;
                dig    <= dig_on ^ {DIGITS{DIG_ACTIVE_LOW}};
            end else begin
                seg    <= {7{SEG_ACTIVE_LOW}};
                seg_dp <= SEG_ACTIVE_LOW;
                dig    <= {DIGITS{DIG_ACTIVE_LOW}};
            end
        end
    end

endmodule

// File: tb/tb_seg_mux_display.sv
// Bench for seg_mux_display: position-in-frame reference model checked every
// cycle on a hex and a BCD instance, plus directed literal checks.
module tb_seg_mux_display;

    localparam logic [6:0] S0 = 7'b0111111;
    localparam logic [6:0] S1 = 7'b0000110;
    localparam logic [6:0] S2 = 7'b1011011;
    localparam logic [6:0] S3 = 7'b1001111;
    localparam logic [6:0] S4 = 7'b1100110;
    localparam logic [6:0] S5 = 7'b1101101;
    localparam logic [6:0] SA = 7'b1110111;
    localparam logic [6:0] SD = 7'b1011110;
    localparam logic [6:0] SF = 7'b1110001;
    localparam logic [6:0] OFF = 7'b0000000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b1;
    logic        load = 1'b0;
    logic        lz_blank = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp = '0;

    logic [6:0]  seg_h, seg_n;
    logic        dp_h, dp_n;
    logic [3:0]  dig_h, dig_n;
    logic        tick_h, tick_n;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seg_mux_display #(.DIGITS(4), .CLK_DIV(4), .DEAD_CYCLES(1), .HEX_MODE(1'b1),
                      .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)) u_hex (
        .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .value(value),
        .dp(dp), .lz_blank(lz_blank), .seg(seg_h), .seg_dp(dp_h), .dig(dig_h),
        .frame_tick(tick_h));

    seg_mux_display #(.DIGITS(4), .CLK_DIV(4), .DEAD_CYCLES(1), .HEX_MODE(1'b0),
                      .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)) u_bcd (
        .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .value(value),
        .dp(dp), .lz_blank(lz_blank), .seg(seg_n), .seg_dp(dp_n), .dig(dig_n),
        .frame_tick(tick_n));

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] n, input bit hex);
        case (n)
            4'h0: seg_of = S0;          4'h1: seg_of = S1;
            4'h2: seg_of = S2;          4'h3: seg_of = S3;
            4'h4: seg_of = S4;          4'h5: seg_of = S5;
            4'h6: seg_of = 7'b1111101;  4'h7: seg_of = 7'b0000111;
            4'h8: seg_of = 7'b1111111;  4'h9: seg_of = 7'b1101111;
            4'hA: seg_of = SA;          4'hB: seg_of = 7'b1111100;
            4'hC: seg_of = 7'b0111001;  4'hD: seg_of = SD;
            4'hE: seg_of = 7'b1111001;  default: seg_of = SF;
        endcase
        if (!hex && n > 4'd9) seg_of = OFF;
    endfunction

    // Reference model: t counts cycles since the scan (re)started; one digit
    // slot is 5 cycles (1 dark + 4 lit), one frame is 20.
    int          t;
    logic [15:0] act, pend;
    logic [3:0]  act_dp, pend_dp;
    logic        pv, m_tick;
    logic [3:0]  e_dig;
    logic [6:0]  e_seg_h, e_seg_n;
    logic        e_dp;
    bit          model_ready = 1'b0;

    initial begin : model
        int p, d, ph;
        logic [3:0] nib;
        logic blank;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                t = 0; act = '0; pend = '0; act_dp = '0; pend_dp = '0;
                pv = 1'b0; m_tick = 1'b0;
            end else begin
                if (m_tick) begin
                    if (load) begin
                        act = value; act_dp = dp;
                    end else if (pv) begin
                        act = pend; act_dp = pend_dp;
                    end
                    pv = 1'b0;
                end else if (load) begin
                    pend = value; pend_dp = dp; pv = 1'b1;
                end
                t = enable ? t + 1 : 0;
                m_tick = (t > 0) && (t % 20 == 0);
            end
            p  = t % 20;
            d  = p / 5;
            ph = p % 5;
            e_dig = '0; e_seg_h = OFF; e_seg_n = OFF; e_dp = 1'b0;
            if (ph != 0) begin
                nib   = act[4*d +: 4];
                blank = lz_blank && (d > 0) && ((act >> (4*d)) == 16'd0);
                e_dig   = 4'b0001 << d;
                e_seg_h = blank ? OFF : seg_of(nib, 1'b1);
                e_seg_n = blank ? OFF : seg_of(nib, 1'b0);
                e_dp    = act_dp[d];
            end
            model_ready = 1'b1;
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            if (model_ready) begin
                check("cmp.hex.dig", dig_h, e_dig);
                check("cmp.hex.seg", seg_h, e_seg_h);
                check("cmp.hex.dp", dp_h, e_dp);
                check("cmp.hex.tick", tick_h, m_tick);
                check("cmp.bcd.dig", dig_n, e_dig);
                check("cmp.bcd.seg", seg_n, e_seg_n);
                check("cmp.bcd.dp", dp_n, e_dp);
                check("cmp.bcd.tick", tick_n, m_tick);
            end
        end
    end

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        @(negedge clk);
        value = v; dp = d; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_tick(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tick_h !== 1'b1 && n < 100);
        check(name, tick_h, 1'b1);
    endtask

    task automatic expect_frame(input string tag, input logic [27:0] segs, input logic [3:0] dps);
        logic [3:0] onehot;
        for (int d = 0; d < 4; d++) begin
            onehot = 4'b0001 << d;
            repeat (4) begin
                @(negedge clk);
                check({tag, ".dig"}, dig_h, onehot);
                check({tag, ".seg"}, seg_h, segs[7*d +: 7]);
                check({tag, ".dp"}, dp_h, dps[d]);
            end
            @(negedge clk);
            check({tag, ".gap"}, dig_h, 4'b0000);
            if (d == 3) check({tag, ".tick"}, tick_h, 1'b1);
        end
    endtask

    initial begin : stimulus
        int n;
        repeat (3) begin
            @(negedge clk);
            check("reset.dig", dig_h, 4'b0000);
            check("reset.seg", {tick_h, dp_h, seg_h}, 9'd0);
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("reset.first_dig", dig_h, 4'b0001);
            check("reset.first_seg", seg_h, S0);
        end
        @(negedge clk);
        check("reset.gap", dig_h, 4'b0000);
        n = 5;
        do begin
            @(negedge clk);
            n++;
        end while (tick_h !== 1'b1 && n < 40);
        check("reset.first_tick_cycle", n, 20);
        $display("reset: first tick after %0d cycles", n);

        do_load(16'h1234, 4'b0000);
        wait_tick("scan.tick");
        expect_frame("scan", {S1, S2, S3, S4}, 4'b0000);
        $display("scan order: value 1234 scanned");

        repeat (3) @(negedge clk);
        do_load(16'h1111, 4'b0000);
        @(negedge clk);
        do_load(16'h2222, 4'b0000);
        repeat (8) @(negedge clk);
        check("dbuf.hold_dig", dig_h, 4'b1000);
        check("dbuf.hold_seg", seg_h, S1);
        wait_tick("dbuf.tick");
        expect_frame("dbuf", {S2, S2, S2, S2}, 4'b0000);
        $display("double buffer: 1111 then 2222, 2222 shown");

        value = 16'hABCD; dp = 4'b0000; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check("collide.dig", dig_h, 4'b0001);
        check("collide.seg", seg_h, SD);
        wait_tick("collide.tick");
        $display("boundary collision: ABCD loaded on tick");

        do_load(16'h00FA, 4'b0000);
        wait_tick("bcd.tick");
        @(negedge clk);
        check("bcd.d0_dig", dig_n, 4'b0001);
        check("bcd.d0_seg", seg_n, OFF);
        check("hex.d0_seg", seg_h, SA);
        repeat (5) @(negedge clk);
        check("bcd.d1_dig", dig_n, 4'b0010);
        check("bcd.d1_seg", seg_n, OFF);
        check("hex.d1_seg", seg_h, SF);
        wait_tick("bcd.tick2");
        $display("hex mode: 00FA decoded in both modes");

        lz_blank = 1'b1;
        do_load(16'h0050, 4'b0100);
        wait_tick("lz.tick");
        expect_frame("lz", {OFF, OFF, S5, S0}, 4'b0100);
        $display("leading zeros: 0050 dp 0100 shown");

        repeat (11) @(negedge clk);
        check("endrop.pre_dig", dig_h, 4'b0100);
        enable = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("endrop.dig", dig_h, 4'b0000);
            check("endrop.seg", seg_h, OFF);
            check("endrop.tick", tick_h, 1'b0);
        end
        enable = 1'b1;
        @(negedge clk);
        check("reen.dig", dig_h, 4'b0001);
        check("reen.seg", seg_h, S0);
        lz_blank = 1'b0;
        wait_tick("reen.tick");
        $display("enable drop: scan restarted at digit 0");

        rst_n = 1'b0; value = 16'hFFFF; load = 1'b1;
        @(negedge clk);
        check("rstload.dig", dig_h, 4'b0000);
        check("rstload.tick", tick_h, 1'b0);
        rst_n = 1'b1; load = 1'b0;
        @(negedge clk);
        check("rstload.dig0", dig_h, 4'b0001);
        check("rstload.seg0", seg_h, S0);
        wait_tick("rstload.tick");
        @(negedge clk);
        check("rstload.next_seg", seg_h, S0);
        $display("reset with load: load discarded");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
